// File: rtl/branch_predictor.sv
// Tagged direction/target predictor: one-cycle fetch lookup, decode-side training,
// bimodal or gshare indexing, and a sweep sequencer that clears the table after reset/clear.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int MODE    = 0,
  parameter int HIST_W  = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        d_stall,
  input  logic        bp_clear,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        init_busy
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              init_busy_q, init_busy_d;
  logic              pred_hit_q, pred_hit_d;
  logic              pred_taken_q, pred_taken_d;
  logic [31:0]       pred_target_q, pred_target_d;

  logic             valid_mem [ENTRIES];
  logic [TAG_W-1:0] tag_mem   [ENTRIES];
  logic [CNT_W-1:0] cnt_mem   [ENTRIES];
  logic [31:0]      tgt_mem   [ENTRIES];

  logic [IDX_W-1:0] ghr_idx, f_idx, u_idx, wr_idx;
  logic [TAG_W-1:0] f_tag, u_tag, wr_tag;
  logic [CNT_W-1:0] u_cnt, wr_cnt;
  logic [31:0]      wr_target;
  logic             f_hit, u_hit, upd_accept, wr_en, wr_valid;
  logic             unused_pc_bits;

  assign ghr_idx = (MODE == 1) ? IDX_W'(ghr_q) : '0;
  assign f_idx   = f_pc[IDX_W+1:2] ^ ghr_idx;
  assign u_idx   = upd_pc[IDX_W+1:2] ^ ghr_idx;
  assign f_tag   = f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{f_pc, upd_pc};

  assign upd_accept = (state_q == S_RUN) && !bp_clear && upd_valid;

  // Lookup reads the table combinationally before this edge's write lands,
  // which gives read-before-write on a same-index collision.
  always_comb begin
    f_hit         = valid_mem[f_idx] && (tag_mem[f_idx] == f_tag);
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (state_q == S_INIT || bp_clear) begin
      pred_hit_d    = 1'b0;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
    end else if (!d_stall) begin
      pred_hit_d    = f_valid && f_hit;
      pred_taken_d  = f_valid && f_hit && cnt_mem[f_idx][CNT_W-1];
      pred_target_d = (f_valid && f_hit) ? tgt_mem[f_idx] : '0;
    end
  end

  always_comb begin
    u_hit     = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
    u_cnt     = cnt_mem[u_idx];
    wr_en     = 1'b0;
    wr_idx    = u_idx;
    wr_valid  = 1'b1;
    wr_tag    = u_tag;
    wr_cnt    = CNT_WEAK;
    wr_target = upd_target;
    if (state_q == S_INIT) begin
      wr_en     = !bp_clear;
      wr_idx    = ptr_q;
      wr_valid  = 1'b0;
      wr_tag    = '0;
      wr_cnt    = '0;
      wr_target = '0;
    end else if (upd_accept) begin
      if (u_hit) begin
        wr_en     = 1'b1;
        wr_target = upd_taken ? upd_target : tgt_mem[u_idx];
        if (upd_taken) begin
          wr_cnt = (u_cnt == CNT_MAX) ? u_cnt : u_cnt + CNT_W'(1);
        end else begin
          wr_cnt = (u_cnt == '0) ? u_cnt : u_cnt - CNT_W'(1);
        end
      end else if (upd_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    if (bp_clear) begin
      state_d = S_INIT;
      ptr_d   = '0;
      ghr_d   = '0;
    end else if (state_q == S_INIT) begin
      ptr_d = ptr_q + IDX_W'(1);
      if (ptr_q == PTR_LAST) state_d = S_RUN;
    end else if (upd_accept) begin
      ghr_d = HIST_W'({ghr_q, upd_taken});
    end
    init_busy_d = (state_d == S_INIT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_INIT;
      ptr_q         <= '0;
      ghr_q         <= '0;
      init_busy_q   <= 1'b1;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ghr_q         <= ghr_d;
      init_busy_q   <= init_busy_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Table contents are not reset; the sweep clears them before any use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      valid_mem[wr_idx] <= wr_valid;
      tag_mem[wr_idx]   <= wr_tag;
      cnt_mem[wr_idx]   <= wr_cnt;
      tgt_mem[wr_idx]   <= wr_target;
    end
  end

  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign init_busy   = init_busy_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences for stall/clear/reset/gshare,
// then random traffic scored against a table-of-entries reference model.
module tb_branch_predictor;
  localparam int ENTRIES = 64;
  localparam logic [31:0] PC_A  = 32'hBFC0_0100;
  localparam logic [31:0] PC_B  = 32'hBFC0_4100;
  localparam logic [31:0] PC_C  = 32'hBFC0_0500;
  localparam logic [31:0] PC_Q  = 32'hBFC0_0000;
  localparam logic [31:0] TGT1  = 32'hBFC0_0200;
  localparam logic [31:0] TGT2  = 32'hBFC0_0300;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic        f_valid = 0, d_stall = 0, bp_clear = 0, upd_valid = 0, upd_taken = 0;
  logic [31:0] f_pc = 0, upd_pc = 0, upd_target = 0;
  logic        pred_hit, pred_taken, init_busy;
  logic [31:0] pred_target;

  logic        g_f_valid = 0, g_d_stall = 0, g_bp_clear = 0, g_upd_valid = 0, g_upd_taken = 0;
  logic [31:0] g_f_pc = 0, g_upd_pc = 0, g_upd_target = 0;
  logic        g_pred_hit, g_pred_taken, g_init_busy;
  logic [31:0] g_pred_target;

  branch_predictor #(.ENTRIES(64), .CNT_W(2), .TAG_W(8), .MODE(0), .HIST_W(6)) dut (
    .clk(clk), .resetn(resetn), .f_valid(f_valid), .f_pc(f_pc), .d_stall(d_stall),
    .bp_clear(bp_clear), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .init_busy(init_busy));

  branch_predictor #(.ENTRIES(64), .CNT_W(2), .TAG_W(8), .MODE(1), .HIST_W(6)) dut_gs (
    .clk(clk), .resetn(resetn), .f_valid(g_f_valid), .f_pc(g_f_pc), .d_stall(g_d_stall),
    .bp_clear(g_bp_clear), .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_taken(g_upd_taken),
    .upd_target(g_upd_target), .pred_hit(g_pred_hit), .pred_taken(g_pred_taken),
    .pred_target(g_pred_target), .init_busy(g_init_busy));

  // Reference model: one record per table slot, counters as plain integers 0..3.
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          busy_left;
  bit          e_hit, e_taken;
  logic [31:0] e_target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit fv; logic [31:0] fpc;
    bit uv; logic [31:0] upc; bit ut; logic [31:0] utgt;
    bit eh; bit et; logic [31:0] etg;
  } vec_t;
  vec_t vecs [17];

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int m_tag_of(input logic [31:0] pc);
    return int'((pc / (4 * ENTRIES)) % 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_cnt[i] = 0; m_tgt[i] = '0;
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
    int i;
    i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == m_tag_of(pc)) begin
      if (taken) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = tgt;
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[i] = 1; m_tag[i] = m_tag_of(pc); m_cnt[i] = 2; m_tgt[i] = tgt;
    end
  endtask

  // One clock of the main DUT: predict from the model, advance it, then compare.
  task automatic step();
    bit in_init;
    int i;
    in_init = (busy_left > 0);
    if (in_init || bp_clear) begin
      e_hit = 0; e_taken = 0; e_target = '0;
    end else if (!d_stall) begin
      i = m_idx(f_pc);
      if (f_valid && m_valid[i] && m_tag[i] == m_tag_of(f_pc)) begin
        e_hit = 1; e_taken = (m_cnt[i] >= 2); e_target = m_tgt[i];
      end else begin
        e_hit = 0; e_taken = 0; e_target = '0;
      end
    end
    if (!in_init && !bp_clear && upd_valid) model_update(upd_pc, upd_taken, upd_target);
    if (bp_clear) begin
      model_clear();
      busy_left = ENTRIES;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    @(posedge clk);
    @(negedge clk);
    chk("model_hit", {31'b0, pred_hit}, {31'b0, e_hit});
    chk("model_taken", {31'b0, pred_taken}, {31'b0, e_taken});
    chk("model_target", pred_target, e_target);
    chk("model_busy", {31'b0, init_busy}, (busy_left > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_clear();
    busy_left = ENTRIES;
    e_hit = 0; e_taken = 0; e_target = '0;
    #1;
    chk("reset_busy", {31'b0, init_busy}, 32'd1);
    chk("reset_hit", {31'b0, pred_hit}, 32'd0);
    chk("reset_taken", {31'b0, pred_taken}, 32'd0);
    chk("reset_target", pred_target, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk(name, n, 32'd64);
    $display("%s: init_busy high for %0d cycles", name, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{0, 32'h0, 1, PC_A, 1, TGT1, 0, 0, 32'h0};
    vecs[1]  = '{1, PC_A,  0, 32'h0, 0, 32'h0, 1, 1, TGT1};
    vecs[2]  = '{1, PC_B,  0, 32'h0, 0, 32'h0, 0, 0, 32'h0};
    vecs[3]  = '{1, PC_A,  1, PC_A, 1, TGT1, 1, 1, TGT1};
    vecs[4]  = '{1, PC_A,  1, PC_A, 1, TGT1, 1, 1, TGT1};
    vecs[5]  = '{1, PC_A,  1, PC_A, 1, TGT1, 1, 1, TGT1};
    vecs[6]  = '{1, PC_A,  1, PC_A, 0, 32'h0, 1, 1, TGT1};
    vecs[7]  = '{1, PC_A,  0, 32'h0, 0, 32'h0, 1, 1, TGT1};
    vecs[8]  = '{0, 32'h0, 1, PC_A, 0, 32'h0, 0, 0, 32'h0};
    vecs[9]  = '{1, PC_A,  0, 32'h0, 0, 32'h0, 1, 0, TGT1};
    vecs[10] = '{0, 32'h0, 1, PC_A, 0, 32'h0, 0, 0, 32'h0};
    vecs[11] = '{0, 32'h0, 1, PC_A, 0, 32'h0, 0, 0, 32'h0};
    vecs[12] = '{0, 32'h0, 1, PC_A, 0, 32'h0, 0, 0, 32'h0};
    vecs[13] = '{1, PC_A,  0, 32'h0, 0, 32'h0, 1, 0, TGT1};
    vecs[14] = '{0, 32'h0, 1, PC_A, 1, TGT1, 0, 0, 32'h0};
    vecs[15] = '{1, PC_A,  1, PC_A, 1, TGT2, 1, 0, TGT1};
    vecs[16] = '{1, PC_A,  0, 32'h0, 0, 32'h0, 1, 1, TGT2};

    // Reset release with lookups requested throughout the sweep.
    #2;
    apply_reset();
    f_valid = 1; f_pc = PC_A;
    count_busy("reset_release_busy");

    for (int k = 0; k < 17; k++) begin
      f_valid = vecs[k].fv; f_pc = vecs[k].fpc;
      upd_valid = vecs[k].uv; upd_pc = vecs[k].upc;
      upd_taken = vecs[k].ut; upd_target = vecs[k].utgt;
      step();
      chk($sformatf("vec%0d_hit", k), {31'b0, pred_hit}, {31'b0, vecs[k].eh});
      chk($sformatf("vec%0d_taken", k), {31'b0, pred_taken}, {31'b0, vecs[k].et});
      chk($sformatf("vec%0d_target", k), pred_target, vecs[k].etg);
      $display("vec %0d fv=%0d pc=%h uv=%0d t=%0d -> hit=%0d taken=%0d tgt=%h",
               k, vecs[k].fv, vecs[k].fpc, vecs[k].uv, vecs[k].ut, pred_hit, pred_taken, pred_target);
    end
    upd_valid = 0;

    // Stall: outputs hold the PC_A prediction while f_pc wanders.
    d_stall = 1; f_valid = 1;
    for (int k = 0; k < 3; k++) begin
      f_pc = (k == 0) ? PC_B : (k == 1) ? PC_Q : PC_C;
      step();
      chk($sformatf("stall%0d_hit", k), {31'b0, pred_hit}, 32'd1);
      chk($sformatf("stall%0d_taken", k), {31'b0, pred_taken}, 32'd1);
      chk($sformatf("stall%0d_target", k), pred_target, TGT2);
      $display("stall %0d pc=%h -> hit=%0d taken=%0d tgt=%h", k, f_pc, pred_hit, pred_taken, pred_target);
    end
    d_stall = 0; f_pc = PC_B;
    step();
    chk("unstall_hit", {31'b0, pred_hit}, 32'd0);
    f_valid = 0;

    // Gshare: same PC with GHR=1 misses, with GHR back at 0 hits.
    g_upd_valid = 1; g_upd_pc = PC_A; g_upd_taken = 1; g_upd_target = 32'h0000_1234;
    step();
    chk("gs_alloc_idle_hit", {31'b0, g_pred_hit}, 32'd0);
    g_upd_valid = 0; g_f_valid = 1; g_f_pc = PC_A;
    step();
    chk("gs_ghr1_hit", {31'b0, g_pred_hit}, 32'd0);
    $display("gshare ghr=1 lookup pc=%h -> hit=%0d", g_f_pc, g_pred_hit);
    g_f_valid = 0; g_upd_valid = 1; g_upd_pc = PC_Q; g_upd_taken = 0;
    repeat (6) step();
    g_upd_valid = 0; g_f_valid = 1; g_f_pc = PC_A;
    step();
    chk("gs_ghr0_hit", {31'b0, g_pred_hit}, 32'd1);
    chk("gs_ghr0_taken", {31'b0, g_pred_taken}, 32'd1);
    chk("gs_ghr0_target", g_pred_target, 32'h0000_1234);
    $display("gshare ghr=0 lookup pc=%h -> hit=%0d taken=%0d tgt=%h", g_f_pc, g_pred_hit, g_pred_taken, g_pred_target);
    g_f_valid = 0;

    // Clear after training; the same-cycle update must be discarded.
    f_valid = 1; f_pc = PC_A;
    bp_clear = 1; upd_valid = 1; upd_pc = PC_C; upd_taken = 1; upd_target = 32'h0000_0100;
    step();
    bp_clear = 0; upd_valid = 0;
    count_busy("clear_busy");
    step();
    chk("clear_pc_a_hit", {31'b0, pred_hit}, 32'd0);
    f_pc = PC_C;
    step();
    chk("clear_upd_dropped_hit", {31'b0, pred_hit}, 32'd0);
    $display("after clear: pc=%h hit=%0d", f_pc, pred_hit);

    // Reset in the middle of a sweep restarts it from the beginning.
    bp_clear = 1;
    step();
    bp_clear = 0;
    repeat (20) step();
    #2;
    apply_reset();
    count_busy("midsweep_reset_busy");

    // Random traffic over a small PC pool so entries collide and alias.
    for (int k = 0; k < 800; k++) begin
      f_valid = ($urandom_range(0, 3) != 0);
      f_pc = 32'hBFC0_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      d_stall = ($urandom_range(0, 7) == 0);
      upd_valid = $urandom_range(0, 1);
      upd_pc = 32'hBFC0_0000 | ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
      upd_taken = $urandom_range(0, 1);
      upd_target = $urandom() & 32'hFFFF_FFFC;
      bp_clear = ($urandom_range(0, 299) == 0);
      step();
      $display("rnd %0d fv=%0d pc=%h st=%0d uv=%0d upc=%h t=%0d clr=%0d -> hit=%0d taken=%0d tgt=%h",
               k, f_valid, f_pc, d_stall, upd_valid, upd_pc, upd_taken, bp_clear,
               pred_hit, pred_taken, pred_target);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
